// File: rtl/regfile_dump_reader.sv
// Debug dump engine: stalls the core and streams every register-file entry as (index, value) beats.
// Optional build macro REGDUMP_SKIP_X0_EN starts the walk at x1 instead of x0.
module regfile_dump_reader #(
  parameter int NUM_REGS = 32,
  parameter int ADDR_W   = 5,
  parameter int DATA_W   = 32
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_start,
  output logic [ADDR_W-1:0] o_rf_addr,
  input  logic [DATA_W-1:0] i_rf_data,
  output logic              o_out_valid,
  input  logic              i_out_ready,
  output logic [ADDR_W-1:0] o_out_addr,
  output logic [DATA_W-1:0] o_out_data,
  output logic              o_busy,
  output logic              o_done
);

`ifdef REGDUMP_SKIP_X0_EN
  localparam logic [ADDR_W-1:0] FIRST = ADDR_W'(1);
`else
  localparam logic [ADDR_W-1:0] FIRST = ADDR_W'(0);
`endif
  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(NUM_REGS - 1);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

  state_t              r_state, w_state_nxt;
  logic [ADDR_W-1:0]   r_idx;
  logic                r_out_valid;
  logic [ADDR_W-1:0]   r_out_addr;
  logic [DATA_W-1:0]   r_out_data;
  logic                r_done;
  logic [ADDR_W-1:0]   w_rf_addr;
  logic                w_load;
  logic                w_accept;

  always_comb begin
    w_state_nxt = r_state;
    w_rf_addr   = '0;
    w_load      = 1'b0;
    w_accept    = r_out_valid && i_out_ready;
    case (r_state)
      IDLE: if (i_start) w_state_nxt = RUN;
      RUN: begin
        w_rf_addr = r_idx;
        // Output register is free when empty or being drained this cycle.
        w_load    = !r_out_valid || i_out_ready;
        if (w_load && r_idx == LAST) w_state_nxt = DRAIN;
      end
      DRAIN: begin
        w_rf_addr = LAST;
        if (w_accept) w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_state     <= IDLE;
      r_idx       <= FIRST;
      r_out_valid <= 1'b0;
      r_out_addr  <= '0;
      r_out_data  <= '0;
      r_done      <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_done  <= 1'b0;
      case (r_state)
        IDLE: r_idx <= FIRST;
        RUN: if (w_load) begin
          r_out_valid <= 1'b1;
          r_out_addr  <= r_idx;
          r_out_data  <= i_rf_data;
          if (r_idx != LAST) r_idx <= r_idx + ADDR_W'(1);
        end
        DRAIN: if (w_accept) begin
          r_out_valid <= 1'b0;
          r_done      <= 1'b1;
          r_idx       <= FIRST;
        end
        default: r_idx <= FIRST;
      endcase
    end
  end

  assign o_rf_addr   = w_rf_addr;
  assign o_out_valid = r_out_valid;
  assign o_out_addr  = r_out_addr;
  assign o_out_data  = r_out_data;
  assign o_busy      = (r_state != IDLE);
  assign o_done      = r_done;

endmodule

// File: tb/tb_regfile_dump_reader.sv
// Directed bench for regfile_dump_reader: reset, full-rate, back-pressure, start-while-busy, mid-dump reset.
module tb_regfile_dump_reader;
  localparam int NUM_REGS = 32;
  localparam int ADDR_W   = 5;
  localparam int DATA_W   = 32;
`ifdef REGDUMP_SKIP_X0_EN
  localparam int FIRST = 1;
`else
  localparam int FIRST = 0;
`endif

  logic              clk = 1'b0;
  logic              rst_n, start, out_ready;
  logic [ADDR_W-1:0] rf_addr, out_addr;
  logic [DATA_W-1:0] rf_data, out_data;
  logic              out_valid, busy, done;
  logic [DATA_W-1:0] rf [NUM_REGS];

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  assign rf_data = rf[rf_addr];

  regfile_dump_reader #(.NUM_REGS(NUM_REGS), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_start(start),
    .o_rf_addr(rf_addr), .i_rf_data(rf_data),
    .o_out_valid(out_valid), .i_out_ready(out_ready),
    .o_out_addr(out_addr), .o_out_data(out_data),
    .o_busy(busy), .o_done(done)
  );

  function automatic logic [31:0] exp_data(int i);
    return (i == 0) ? 32'h0 : 32'hA5A5_0000 + 32'(i);
  endfunction

  task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk); #1;
  endtask

  // Start a dump and follow it to done; bp stalls beat 5 for 3 cycles,
  // xs pulses start again while beats 3 and 31 are presented.
  task automatic do_dump(bit bp, bit xs);
    int exp, beats, dones, hold, ncyc;
    bit acc;
    exp = FIRST; beats = 0; dones = 0; hold = 0; ncyc = 0;
    start = 1'b1; out_ready = 1'b1;
    step();
    start = 1'b0;
    chk("busy_after_start", busy, 1);
    chk("no_beat_yet", out_valid, 0);
    while (dones == 0 && ncyc < 200) begin
      acc = 1'b0;
      start = 1'b0;
      out_ready = 1'b1;
      if (ncyc > 0 && exp < NUM_REGS) chk("valid", out_valid, (bp && exp == 5 && hold > 0 && hold < 4) ? 1 : 1);
      if (out_valid) begin
        chk("out_addr", out_addr, exp);
        chk("out_data", out_data, exp_data(exp));
        if (bp && exp == 5 && hold < 3) begin
          out_ready = 1'b0;
          hold++;
        end else acc = 1'b1;
        if (xs && (exp == 3 || exp == NUM_REGS - 1)) start = 1'b1;
      end
      step();
      ncyc++;
      if (acc) begin exp++; beats++; end
      if (done) begin
        dones++;
        chk("busy_at_done", busy, 0);
        chk("valid_at_done", out_valid, 0);
      end else if (exp < NUM_REGS) chk("busy_mid", busy, 1);
    end
    start = 1'b0;
    chk("done_seen", dones, 1);
    chk("beat_count", beats, NUM_REGS - FIRST);
    if (!bp) chk("dump_cycles", ncyc, NUM_REGS + 1 - FIRST);
    else     chk("dump_cycles_bp", ncyc, NUM_REGS + 4 - FIRST);
    step();
    chk("done_pulse_end", done, 0);
    chk("idle_after", busy, 0);
    chk("rf_addr_idle", rf_addr, 0);
  endtask

  initial begin
    for (int i = 0; i < NUM_REGS; i++) rf[i] = exp_data(i);
    rst_n = 1'b0; start = 1'b1; out_ready = 1'b1;

    // Reset held with start asserted
    for (int c = 0; c < 3; c++) begin
      step();
      chk("rst_valid", out_valid, 0);
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_rf_addr", rf_addr, 0);
      chk("rst_out_addr", out_addr, 0);
      chk("rst_out_data", out_data, 0);
    end
    rst_n = 1'b1; start = 1'b0;
    for (int c = 0; c < 3; c++) begin
      step();
      chk("idle_busy", busy, 0);
      chk("idle_valid", out_valid, 0);
    end

    do_dump(1'b0, 1'b0);   // full rate
    do_dump(1'b1, 1'b0);   // back-pressure on beat 5
    do_dump(1'b0, 1'b1);   // start pulses while busy
    step();
    chk("no_restart", busy, 0);

    // Reset in the middle of a dump
    start = 1'b1; out_ready = 1'b1;
    step();
    start = 1'b0;
    for (int c = 0; c < 50 && !(out_valid && out_addr == 10); c++) step();
    chk("reached_beat10", out_addr, 10);
    rst_n = 1'b0;
    step();
    chk("mid_rst_valid", out_valid, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_done", done, 0);
    rst_n = 1'b1;
    step();
    chk("post_rst_done", done, 0);
    chk("post_rst_busy", busy, 0);
    do_dump(1'b0, 1'b0);   // fresh dump after abort

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
